// File: rtl/spi_master_transmit_pkg.sv
// Shared constants, state type and frame packing for the SPI cursor transmitter.
package spi_tx_pkg;

    localparam int FRAME_BITS = 32;
    localparam int X_LSB      = 16;
    localparam int Y_LSB      = 0;
    localparam int COORD_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_SYNC  = 2'd3
    } state_e;

    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[X_LSB +: COORD_W] = x;
        w[Y_LSB +: COORD_W] = y;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_transmit_if.sv
// Valid/ready coordinate handshake between a producer and the SPI transmitter.
interface spi_master_transmit_if;
    import spi_tx_pkg::*;

    logic               valid;
    logic               ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    modport master (output valid, output x, output y, input ready);
    modport slave  (input valid, input x, input y, output ready);

endinterface

// File: rtl/spi_master_transmit_clk_div.sv
// sck generator: CLK_DIV cycles low then CLK_DIV high, with one-cycle rise/fall strobes.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_sck;
    logic       w_wrap;

    // Strobes mark the edge on which sck is about to toggle.
    assign w_wrap = i_en & (r_cnt == 8'(CLK_DIV - 1));
    assign o_rise = w_wrap & ~r_sck;
    assign o_fall = w_wrap & r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_transmit.sv
// SPI transmitter for 32-bit {x,y} cursor frames, MSB first, idle-low sck.
// Define SPI_TX_SYNC_EN to send one all-zero alignment frame after reset.
module spi_master_transmit
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_master_transmit_if.slave  bus,
    output logic                  sck,
    output logic                  sdo,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_GAP   = ST_GAP;
`ifdef SPI_TX_SYNC_EN
    localparam logic [1:0] S_SYNC  = ST_SYNC;
`endif

    logic [1:0]            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_bit;
    logic                  r_last;
    logic [7:0]            r_gap;
    logic                  w_run;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_accept;

`ifdef SPI_TX_SYNC_EN
    logic r_pend;

    assign bus.ready = (r_state == S_IDLE) & ~r_pend;
    assign w_run     = (r_state == S_SHIFT) | (r_state == S_SYNC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pend <= 1'b1;
        else if (r_state == S_IDLE)
            r_pend <= 1'b0;
    end
`else
    assign bus.ready = (r_state == S_IDLE);
    assign w_run     = (r_state == S_SHIFT);
`endif

    assign w_accept = bus.valid & bus.ready;
    assign busy     = (r_state != S_IDLE);
    assign sdo      = w_run & r_shift[FRAME_BITS-1];

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_run),
        .o_sck   (sck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_last  <= 1'b0;
            r_gap   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
`ifdef SPI_TX_SYNC_EN
                    if (r_pend) begin
                        r_state <= S_SYNC;
                        r_shift <= '0;
                        r_bit   <= '0;
                        r_last  <= 1'b0;
                    end else
`endif
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        r_shift <= frame_word(bus.x, bus.y);
                        r_bit   <= '0;
                        r_last  <= 1'b0;
                    end
                end
`ifdef SPI_TX_SYNC_EN
                S_SHIFT, S_SYNC: begin
`else
                S_SHIFT: begin
`endif
                    // Final bit is armed on the 32nd rise so the counter never wraps.
                    if (w_rise && r_bit == 5'd31)
                        r_last <= 1'b1;
                    if (w_fall) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        if (r_last) begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == 8'(GAP - 1))
                        r_state <= S_IDLE;
                    else
                        r_gap <= r_gap + 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_transmit.sv
// Self-checking bench for spi_master_transmit: vector table, random frames, corner sequences.
module tb_spi_master_transmit;

    localparam int D  = 4;
    localparam int G  = 8;
    localparam int FD = 1;
    localparam int FG = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frst_n = 1'b0;
    logic sck, sdo, busy;
    logic fsck, fsdo, fbusy;

    int checks = 0;
    int errors = 0;

    spi_master_transmit_if b ();
    spi_master_transmit_if fb ();

    spi_master_transmit #(.CLK_DIV(D), .GAP(G)) dut (
        .clk(clk), .reset_n(rst_n), .bus(b), .sck(sck), .sdo(sdo), .busy(busy)
    );

    spi_master_transmit #(.CLK_DIV(FD), .GAP(FG)) dut_fast (
        .clk(clk), .reset_n(frst_n), .bus(fb), .sck(fsck), .sdo(fsdo), .busy(fbusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int x, input int y);
        return 32'(x * 65536 + y);
    endfunction

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!b.ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!b.ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_frame(
        input  logic [9:0]  ix,
        input  logic [9:0]  iy,
        input  bit          intrude,
        output logic [31:0] word,
        output int          nrise,
        output int          nbusy,
        output int          first_rise,
        output int          bad
    );
        logic ps, pd;
        wait_ready("frame");
        b.x = ix;
        b.y = iy;
        b.valid = 1'b1;
        @(negedge clk);
        b.valid = 1'b0;
        b.x = 10'($urandom);
        b.y = 10'($urandom);
        word = '0; nrise = 0; nbusy = 0; first_rise = 0; bad = 0;
        ps = 1'b0; pd = sdo;
        while (busy && nbusy < 5000) begin
            nbusy++;
            if (sck && !ps) begin
                nrise++;
                word = {word[30:0], sdo};
                if (first_rise == 0) first_rise = nbusy;
            end
            if (nbusy > 1 && sdo !== pd && !(ps && !sck)) bad++;
            if (b.ready) bad++;
            if (intrude && nbusy == 20) begin
                b.valid = 1'b1;
                b.x = 10'($urandom);
                b.y = 10'($urandom);
            end
            if (intrude && nbusy == 100) b.valid = 1'b0;
            ps = sck;
            pd = sdo;
            @(negedge clk);
        end
        if (sdo !== 1'b0 || sck !== 1'b0) bad++;
    endtask

    task automatic check_frame(input string nm, input logic [31:0] exp, input bit intrude);
        logic [31:0] w;
        int nr, nb, fr, bad;
        run_frame(exp[25:16], exp[9:0], intrude, w, nr, nb, fr, bad);
        chk({nm, "_word"}, w, exp);
        chk({nm, "_rises"}, 32'(nr), 32'd32);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(64 * D + G));
        chk({nm, "_first_rise"}, 32'(fr), 32'(D + 1));
        chk({nm, "_protocol"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [31:0] w;
        logic [31:0] q[$];
        int acc[$];
        logic [31:0] fsr;
        logic fprev;
        int nr, fn, cmpd, t;

        b.valid = 1'b0; b.x = '0; b.y = '0;
        fb.valid = 1'b0; fb.x = '0; fb.y = '0;

        vecs[0] = '{x: 10'd320,  y: 10'd240,  exp: 32'h014000F0};
        vecs[1] = '{x: 10'h3FF,  y: 10'h3FF,  exp: 32'h03FF03FF};
        vecs[2] = '{x: 10'd0,    y: 10'd0,    exp: 32'h00000000};
        vecs[3] = '{x: 10'h001,  y: 10'h200,  exp: 32'h00010200};
        vecs[4] = '{x: 10'h155,  y: 10'h2AA,  exp: 32'h015502AA};

        #22;
        chk("rst_sck", {31'd0, sck}, 32'd0);
        chk("rst_sdo", {31'd0, sdo}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_TX_SYNC_EN
        chk("rst_ready", {31'd0, b.ready}, 32'd0);
`else
        chk("rst_ready", {31'd0, b.ready}, 32'd1);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        frst_n = 1'b1;

`ifdef SPI_TX_SYNC_EN
        begin
            int sbad;
            logic ps;
            bit seen;
            b.valid = 1'b1; b.x = 10'h3FF; b.y = 10'h3FF;
            nr = 0; sbad = 0; ps = 1'b0; seen = 1'b0; t = 0;
            @(negedge clk);
            while (t < 3000 && !(seen && !busy)) begin
                if (busy) seen = 1'b1;
                if (busy && b.ready) sbad++;
                if (sck && !ps) begin
                    nr++;
                    if (sdo) sbad++;
                end
                ps = sck;
                t++;
                @(negedge clk);
            end
            b.valid = 1'b0;
            chk("sync_rises", 32'(nr), 32'd32);
            chk("sync_bad", 32'(sbad), 32'd0);
            chk("sync_ready_after", {31'd0, b.ready}, 32'd1);
        end
`endif

        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
            chk($sformatf("vec%0d_model", i), model_word(vecs[i].x, vecs[i].y), vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            int rx, ry;
            rx = $urandom_range(0, 1023);
            ry = $urandom_range(0, 1023);
            check_frame($sformatf("rnd%0d", i), model_word(rx, ry), 1'b0);
        end

        // Offer a new pair mid-frame: must be neither accepted nor queued.
        check_frame("busy_valid", model_word(700, 55), 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_valid_not_queued", {31'd0, busy}, 32'd0);

        // Reset at the 10th sck rise.
        wait_ready("rst");
        b.x = 10'd999; b.y = 10'd1; b.valid = 1'b1;
        @(negedge clk);
        b.valid = 1'b0;
        begin
            logic ps;
            ps = 1'b0; nr = 0; t = 0;
            while (nr < 10 && t < 2000) begin
                if (sck && !ps) nr++;
                ps = sck;
                if (nr < 10) @(negedge clk);
                t++;
            end
            chk("rst_mid_reached", 32'(nr), 32'd10);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_sck", {31'd0, sck}, 32'd0);
            chk("rst_mid_sdo", {31'd0, sdo}, 32'd0);
            chk("rst_mid_busy", {31'd0, busy}, 32'd0);
            nr = 0;
            repeat (4) begin
                @(negedge clk);
                if (sck) nr++;
            end
            chk("rst_mid_no_edges", 32'(nr), 32'd0);
            rst_n = 1'b1;
        end
        check_frame("after_rst", model_word(123, 456), 1'b0);
        begin
            logic [31:0] wd;
            wd = model_word(1023, 1023);
            chk("decode_x", {22'd0, wd[25:16]}, 32'd1023);
            chk("decode_y", {22'd0, wd[9:0]}, 32'd1023);
        end

        // Back-to-back frames on the CLK_DIV=1, GAP=1 instance.
        t = 0;
        while (!fb.ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        fb.valid = 1'b1;
        fprev = 1'b0; fsr = '0; fn = 0; cmpd = 0;
        for (int c = 0; c < 260; c++) begin
            fb.x = 10'($urandom);
            fb.y = 10'($urandom);
            if (fb.ready) begin
                q.push_back(model_word(int'(fb.x), int'(fb.y)));
                acc.push_back(c);
            end
            if (fsck && !fprev) begin
                fsr = {fsr[30:0], fsdo};
                fn++;
                if (fn == 32) begin
                    fn = 0;
                    if (q.size() > 0) begin
                        w = q.pop_front();
                        chk($sformatf("fast_word%0d", cmpd), fsr, w);
                        cmpd++;
                    end
                end
            end
            fprev = fsck;
            @(negedge clk);
        end
        fb.valid = 1'b0;
        chk("fast_accepts", 32'(acc.size() >= 3), 32'd1);
        chk("fast_frames", 32'(cmpd >= 3), 32'd1);
        for (int i = 1; i < acc.size(); i++)
            chk($sformatf("fast_period%0d", i), 32'(acc[i] - acc[i-1]), 32'(64 * FD + FG + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
